// File: rtl/myproject_sdiv_32s_16s_16_seq.sv
// Sequential signed restoring divider (32s / 16s -> 16s quotient, 16s remainder), one quotient bit per cycle.
// Result valid 33 cycles after accept; the result is held in DONE until out_ready, and no new operands are taken until then.
module myproject_sdiv_32s_16s_16_seq #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CW = $clog2(din0_WIDTH);
    localparam logic [CW-1:0]         CNT_LAST = CW'(din0_WIDTH - 1);
    localparam logic [din0_WIDTH-1:0] QPOS_MAX = din0_WIDTH'((2 ** (dout_WIDTH - 1)) - 1);
    localparam logic [din0_WIDTH-1:0] QNEG_MAX = din0_WIDTH'(2 ** (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] SAT_POS  = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] SAT_NEG  = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [din0_WIDTH-1:0] ONE0     = {{(din0_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [din1_WIDTH-1:0] ONE1     = {{(din1_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [dout_WIDTH-1:0] ONEQ     = {{(dout_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [din0_WIDTH-1:0] quo;
    logic [din1_WIDTH:0]   pr;
    logic [din1_WIDTH-1:0] dsr;
    logic [din1_WIDTH-1:0] dlow;
    logic [CW-1:0]         cnt;
    logic                  sign0, sign1, zdiv;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !ap_rst;
                if (in_valid && !ap_rst) state_nxt = CALC;
            end
            CALC: if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend MSB, subtract when it fits.
    logic [din1_WIDTH:0] pr_sh, pr_sub;
    logic                pr_ge;
    assign pr_sh  = {pr[din1_WIDTH-1:0], quo[din0_WIDTH-1]};
    assign pr_ge  = pr_sh >= {1'b0, dsr};
    assign pr_sub = pr_sh - {1'b0, dsr};

    logic                  qneg;
    logic [dout_WIDTH-1:0] qlow;
    logic [din1_WIDTH-1:0] rmag;
    logic [dout_WIDTH-1:0] fix_dout;
    logic [din1_WIDTH-1:0] fix_rem;
    logic                  fix_ovf;
    assign qneg = sign0 ^ sign1;
    assign qlow = quo[dout_WIDTH-1:0];
    assign rmag = pr[din1_WIDTH-1:0];

    always_comb begin
        fix_dout = qneg ? (~qlow + ONEQ) : qlow;
        fix_rem  = sign0 ? (~rmag + ONE1) : rmag;
        fix_ovf  = 1'b0;
        if (zdiv) begin
            fix_dout = sign0 ? SAT_NEG : SAT_POS;
            fix_rem  = dlow;
        end else if (qneg && (quo > QNEG_MAX)) begin
            fix_dout = SAT_NEG;
            fix_ovf  = 1'b1;
        end else if (!qneg && (quo > QPOS_MAX)) begin
            fix_dout = SAT_POS;
            fix_ovf  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            quo   <= '0;
            pr    <= '0;
            dsr   <= '0;
            dlow  <= '0;
            cnt   <= '0;
            sign0 <= 1'b0;
            sign1 <= 1'b0;
            zdiv  <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    quo   <= din0[din0_WIDTH-1] ? (~din0 + ONE0) : din0;
                    dsr   <= din1[din1_WIDTH-1] ? (~din1 + ONE1) : din1;
                    dlow  <= din0[din1_WIDTH-1:0];
                    sign0 <= din0[din0_WIDTH-1];
                    sign1 <= din1[din1_WIDTH-1];
                    zdiv  <= (din1 == '0);
                    pr    <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    pr  <= pr_ge ? pr_sub : pr_sh;
                    quo <= {quo[din0_WIDTH-2:0], pr_ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    dout <= fix_dout;
                    rem  <= fix_rem;
                    ovf  <= fix_ovf;
                    dbz  <= zdiv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_sdiv_32s_16s_16_seq.sv
// Directed and random checks of the sequential signed divider: signs, saturation, divide-by-zero, backpressure, reset abort, throughput.
module tb_myproject_sdiv_32s_16s_16_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] dout;
    logic [15:0] rem;
    logic        ovf;
    logic        dbz;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;

    myproject_sdiv_32s_16s_16_seq dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<500000", $time);
        $fatal(1, "watchdog");
    end

    // Issues one operation and waits (bounded) for the result; returns what was observed.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic o, output logic z, output int lat, output int acc);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge ap_clk); #1; w++;
        end
        din0 = a; din1 = b; in_valid = 1'b1;
        @(posedge ap_clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge ap_clk); #1; lat++;
        end
        q = dout; r = rem; o = ovf; z = dbz;
        if (out_ready) begin
            @(posedge ap_clk); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({in_ready, out_valid, dout, rem, ovf, dbz} !== 35'd0) begin
            failed++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b dout=%h rem=%h ovf=%b dbz=%b, want all 0",
                     in_ready, out_valid, dout, rem, ovf, dbz);
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_signs();
        logic [31:0] ta [4];
        logic [15:0] tb [4];
        logic [15:0] tq [4];
        logic [15:0] tr [4];
        logic [15:0] q, r;
        logic o, z;
        int lat, acc;
        ta[0] = 32'd1000;   tb[0] = 16'd7;   tq[0] = 16'd142;        tr[0] = 16'd6;
        ta[1] = -32'sd1000; tb[1] = 16'd7;   tq[1] = -16'sd142;      tr[1] = -16'sd6;
        ta[2] = 32'd1000;   tb[2] = -16'sd7; tq[2] = -16'sd142;      tr[2] = 16'd6;
        ta[3] = -32'sd1000; tb[3] = -16'sd7; tq[3] = 16'd142;        tr[3] = -16'sd6;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, o, z, lat, acc);
            tests_run++;
            if ({q, r, o, z} !== {tq[i], tr[i], 1'b0, 1'b0}) begin
                failed++;
                $display("FAIL signs[%0d]: got q=%0d r=%0d ovf=%b dbz=%b, want q=%0d r=%0d ovf=0 dbz=0",
                         i, $signed(q), $signed(r), o, z, $signed(tq[i]), $signed(tr[i]));
            end
            tests_run++;
            if (lat !== 33) begin
                failed++;
                $display("FAIL signs_latency[%0d]: got %0d want 33", i, lat);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ta [4];
        logic [15:0] tb [4];
        logic [15:0] tq [4];
        logic        to [4];
        logic [15:0] q, r;
        logic o, z;
        int lat, acc;
        ta[0] = 32'h4000_0000; tb[0] = 16'd1;      tq[0] = 16'h7FFF; to[0] = 1'b1;
        ta[1] = 32'h8000_0000; tb[1] = 16'hFFFF;   tq[1] = 16'h7FFF; to[1] = 1'b1;
        ta[2] = -32'sd32768;   tb[2] = 16'd1;      tq[2] = 16'h8000; to[2] = 1'b0;
        ta[3] = 32'd32768;     tb[3] = 16'hFFFF;   tq[3] = 16'h8000; to[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, o, z, lat, acc);
            tests_run++;
            if ({q, r, o, z} !== {tq[i], 16'd0, to[i], 1'b0}) begin
                failed++;
                $display("FAIL overflow[%0d]: got q=%h r=%h ovf=%b dbz=%b, want q=%h r=0000 ovf=%b dbz=0",
                         i, q, r, o, z, tq[i], to[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [15:0] q, r;
        logic o, z;
        int lat, acc;
        run_op(32'd5, 16'd0, q, r, o, z, lat, acc);
        tests_run++;
        if ({q, r, o, z, lat} !== {16'h7FFF, 16'd5, 1'b0, 1'b1, 32'd33}) begin
            failed++;
            $display("FAIL dbz_pos: got q=%h r=%h ovf=%b dbz=%b lat=%0d, want 7fff 0005 0 1 33", q, r, o, z, lat);
        end
        run_op(-32'sd5, 16'd0, q, r, o, z, lat, acc);
        tests_run++;
        if ({q, r, o, z, lat} !== {16'h8000, 16'hFFFB, 1'b0, 1'b1, 32'd33}) begin
            failed++;
            $display("FAIL dbz_neg: got q=%h r=%h ovf=%b dbz=%b lat=%0d, want 8000 fffb 0 1 33", q, r, o, z, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] q, r;
        logic o, z;
        int lat, acc;
        out_ready = 1'b0;
        run_op(32'd1000, 16'd7, q, r, o, z, lat, acc);
        tests_run++;
        if ({q, r} !== {16'd142, 16'd6}) begin
            failed++;
            $display("FAIL bp_result: got q=%0d r=%0d want 142 6", q, r);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge ap_clk); #1;
            if (k == 3) begin
                din0 = 32'd77; din1 = 16'd2; in_valid = 1'b1;
            end
            if (k == 4) in_valid = 1'b0;
            tests_run++;
            if ({out_valid, in_ready, dout, rem, ovf, dbz} !== {1'b1, 1'b0, 16'd142, 16'd6, 1'b0, 1'b0}) begin
                failed++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b dout=%0d rem=%0d ovf=%b dbz=%b, want 1 0 142 6 0 0",
                         k, out_valid, in_ready, dout, rem, ovf, dbz);
            end
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failed++;
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] q, r;
        logic o, z;
        int lat, acc;
        run_op(-32'sd1000, -16'sd7, q, r, o, z, lat, acc);
        din0 = 32'd999; din1 = 16'd4; in_valid = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_valid, dout, rem, ovf, dbz} !== 35'd0) begin
            failed++;
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b dout=%h rem=%h ovf=%b dbz=%b, want all 0",
                     in_ready, out_valid, dout, rem, ovf, dbz);
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        run_op(32'd100, 16'd3, q, r, o, z, lat, acc);
        tests_run++;
        if ({q, r, o, z, lat} !== {16'd33, 16'd1, 1'b0, 1'b0, 32'd33}) begin
            failed++;
            $display("FAIL reset_recover: got q=%0d r=%0d ovf=%b dbz=%b lat=%0d, want 33 1 0 0 33", q, r, o, z, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [15:0] b, q, r, eq, er;
        logic o, z, eo, ez;
        longint la, lb, lq, lr;
        int lat, acc, prev;
        prev = 0;
        for (int i = 0; i < 50; i++) begin
            a = (i % 3 == 0) ? 32'($urandom) : 32'($signed(20'($urandom)));
            b = (i % 10 == 7) ? 16'd0 : 16'($urandom);
            if (i == 5) b = 16'hFFFF;
            la = $signed(a);
            lb = $signed(b);
            eo = 1'b0;
            ez = 1'b0;
            if (lb == 0) begin
                eq = (la >= 0) ? 16'h7FFF : 16'h8000;
                er = a[15:0];
                ez = 1'b1;
            end else begin
                lq = la / lb;
                lr = la % lb;
                er = lr[15:0];
                if (lq > 32767) begin
                    eq = 16'h7FFF; eo = 1'b1;
                end else if (lq < -32768) begin
                    eq = 16'h8000; eo = 1'b1;
                end else begin
                    eq = lq[15:0];
                end
            end
            run_op(a, b, q, r, o, z, lat, acc);
            tests_run++;
            if ({q, r, o, z} !== {eq, er, eo, ez}) begin
                failed++;
                $display("FAIL b2b[%0d] %0d/%0d: got q=%h r=%h ovf=%b dbz=%b, want q=%h r=%h ovf=%b dbz=%b",
                         i, la, lb, q, r, o, z, eq, er, eo, ez);
            end
            if (i > 0) begin
                tests_run++;
                if (acc - prev !== 35) begin
                    failed++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles want 35", i, acc - prev);
                end
            end
            prev = acc;
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_overflow();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/myproject_sdiv_32s_16s_16_seq.md
# myproject_sdiv_32s_16s_16_seq

Sequential signed divider, the inverse of the project's single-cycle `myproject_mul_16s_16s_32_1_1` multiplier. It takes a 32-bit signed dividend and a 16-bit signed divisor and returns a 16-bit signed quotient and remainder using restoring division, one bit per cycle, behind a valid/ready handshake. It is used in the HEPT kernel datapath to rescale accumulated 32-bit products back to 16-bit operands (normalisation, averaging).

## Interface
- din0_WIDTH, 32, dividend width (signed)
- din1_WIDTH, 16, divisor width (signed); also the remainder width
- dout_WIDTH, 16, quotient width (signed)
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- din0  in  din0_WIDTH  dividend
- din1  in  din1_WIDTH  divisor
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- dout  out  dout_WIDTH  quotient, saturated
- rem  out  din1_WIDTH  remainder
- ovf  out  1  quotient saturated because of overflow
- dbz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state == IDLE) and not ap_rst.
- IDLE to CALC when in_valid && in_ready. On that edge:
  - latch |din0| as a 32-bit unsigned magnitude (-2^31 gives 2^31);
  - latch |din1| as a 16-bit unsigned magnitude;
  - latch both sign bits and dbz = (din1 == 0);
  - clear the partial remainder (17 bits), clear the counter, load the quotient register with the dividend magnitude.
- CALC, one edge per quotient bit, din0_WIDTH edges in total:
  - shift the partial remainder left and bring in the next dividend MSB;
  - if partial remainder >= divisor magnitude, subtract and shift in 1, else shift in 0.
  - On the last edge (counter == din0_WIDTH-1), go to FIX.
- FIX, one edge, registers the outputs and goes to DONE:
  - qneg = sign0 XOR sign1. The quotient truncates toward zero. The remainder takes the dividend's sign; a zero remainder stays zero.
  - Saturation: if qneg and magnitude > 2^15, dout = -32768. If not qneg and magnitude > 32767, dout = 32767. In both cases ovf = 1. Otherwise dout = the signed quotient and ovf = 0.
  - dbz: division still runs with the fixed latency. Outputs are overridden: dout = 32767 if dividend >= 0, else -32768; rem = din0[15:0] as latched; ovf = 0; dbz = 1.
- DONE: out_valid = 1. dout, rem, ovf and dbz are held stable until out_valid && out_ready, then the block returns to IDLE.
- Inputs are ignored outside IDLE. Only one operation is in flight at a time.

## Timing
- Reset value of every output: in_ready 0 while ap_rst is high, 1 from the first cycle after release; out_valid 0; dout 0; rem 0; ovf 0; dbz 0. State goes to IDLE.
- Latency is fixed. With the accept edge as E0, CALC occupies E1..E32, FIX happens at E33, and out_valid is high from the cycle after E33, i.e. 33 cycles after accept. Latency does not depend on the data, including dbz.
- Result handshake at edge Ed moves to IDLE; in_ready is high in the next cycle. Minimum issue interval is 35 cycles with out_ready held high.
- With out_ready low, out_valid and all result outputs hold indefinitely and in_ready stays 0.
- ap_rst asserted at any point (CALC, FIX, DONE) immediately clears the outputs and state. The partial result is discarded and is never presented.
- in_valid asserted while not in IDLE: no effect, no latching.
- Width rules: partial remainder din1_WIDTH+1 bits. Quotient magnitude din0_WIDTH bits unsigned. Final remainder fits din1_WIDTH signed, since its magnitude is at most 32767.

## Test plan
- Sign combinations:
  - 1000 / 7 -> dout 142, rem 6, ovf 0, dbz 0; out_valid rises exactly 33 cycles after accept.
  - -1000 / 7 -> dout -142, rem -6.
  - 1000 / -7 -> dout -142, rem 6.
  - -1000 / -7 -> dout 142, rem -6.
- Overflow:
  - 0x40000000 / 1 -> dout 32767, rem 0, ovf 1.
  - -2147483648 / -1 -> dout 32767, ovf 1.
  - -32768 / 1 -> dout -32768, ovf 0.
  - 32768 / -1 -> dout -32768, ovf 0 (the negative bound is exact).
- Divide by zero:
  - 5 / 0 -> dout 32767, rem 5, dbz 1, latency still 33.
  - -5 / 0 -> dout -32768, rem -5 (0xFFFB), dbz 1.
- Backpressure: hold out_ready low for 10 cycles after out_valid. Outputs stay stable, in_ready stays 0, and an in_valid pulse during this window is ignored. Handshake, then in_ready is 1 on the next cycle.
- Reset mid-operation: assert ap_rst at cycle 12 of CALC. All outputs go to 0 asynchronously. After release, a new 100 / 3 gives dout 33, rem 1 with no trace of the aborted operation.
- Back-to-back: 50 random operand pairs with out_ready tied high. Each result matches the C truncating divide and remainder plus the saturation and dbz rules above, and accepts are spaced 35 cycles apart.
